// File: rtl/clock_div_pkg.sv
// clock_div_pkg: shared state encoding and phase-length helper for clock_div_gen
package clock_div_pkg;
   typedef enum logic [1:0] {OFF, HIGH, LOW} state_t;
   localparam int MIN_DIV = 2;
   typedef struct packed {
      int h;
      int l;
   } phase_t;
   function automatic phase_t phases(int n);
      int neff;
      neff = n < MIN_DIV ? MIN_DIV : n;
      return phase_t'{h: neff / 2, l: neff - neff / 2};
   endfunction
endpackage

// File: rtl/clock_div_ratio.sv
// clock_div_ratio: holds pending ratio and commits it at period boundaries
module clock_div_ratio
   import clock_div_pkg::*;
#(
   parameter int DIV_W   = 8,
   parameter int DEF_DIV = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             apply_ok,
   input  logic [DIV_W-1:0] div_val,
   input  logic             div_load,
   output logic             div_ack,
   output logic [DIV_W-1:0] cur_div
);
   logic [DIV_W-1:0] pend;
   logic             pend_v;
   always_ff @(posedge clk) begin
      if (rst) begin
         cur_div <= DIV_W'(DEF_DIV);
         pend    <= '0;
         pend_v  <= 1'b0;
         div_ack <= 1'b0;
      end else begin
         div_ack <= apply_ok && pend_v;
         if (apply_ok && pend_v) cur_div <= pend;
         // a load coinciding with an apply stays pending for the next boundary
         pend_v <= div_load || (pend_v && !apply_ok);
         if (div_load) pend <= div_val;
      end
   end
endmodule

// File: rtl/clock_div_gen.sv
// clock_div_gen: glitch-free programmable clock divider/gater producing clk_out and clk_en
module clock_div_gen
   import clock_div_pkg::*;
#(
   parameter int DIV_W   = 8,
   parameter int DEF_DIV = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en_req,
   input  logic [DIV_W-1:0] div_val,
   input  logic             div_load,
   output logic             div_ack,
   output logic             clk_out,
   output logic             clk_en,
   output logic [DIV_W-1:0] cur_div
);
   localparam logic [DIV_W-1:0] ONE = DIV_W'(1);
   state_t           state, nxt;
   logic [DIV_W-1:0] phase, h_m1, l_m1;
   logic             last, apply_ok;
   phase_t           pl;
   always_comb begin
      pl = phases(int'(cur_div));
      h_m1 = DIV_W'(pl.h - 1);
      l_m1 = DIV_W'(pl.l - 1);
      last = phase == (state == HIGH ? h_m1 : l_m1);
      nxt = state == OFF ? (en_req ? HIGH : OFF) :
            !last        ? state :
            state == HIGH ? LOW : (en_req ? HIGH : OFF);
      // every period boundary (and any idle cycle) may commit a pending ratio
      apply_ok = state == OFF || (state == LOW && last);
   end
   clock_div_ratio #(.DIV_W(DIV_W), .DEF_DIV(DEF_DIV)) u_ratio (
      .clk      (clk),
      .rst      (rst),
      .apply_ok (apply_ok),
      .div_val  (div_val),
      .div_load (div_load),
      .div_ack  (div_ack),
      .cur_div  (cur_div)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= OFF;
         phase   <= '0;
         clk_out <= 1'b0;
         clk_en  <= 1'b0;
      end else begin
         state   <= nxt;
         phase   <= (nxt == state && state != OFF) ? phase + ONE : '0;
         clk_out <= nxt == HIGH;
         clk_en  <= nxt != OFF;
      end
   end
endmodule
